hazard_unit_sb: RTL and testbench

- Next-generation hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Generates per-stage stall/flush and E-stage forwarding selects.
- Adds a scoreboard for one multi-cycle execution unit (mul/div) and cache-miss freeze.
- Keeps a saturating stall-cycle performance counter.
- Register-index width is parametrised.

---
 rtl/hazard_unit_sb_if.sv | 61 ++++++
 rtl/hazard_unit_sb.sv | 125 ++++++++++++
 tb/tb_hazard_unit_sb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_sb_if.sv
// Purpose: pipeline <-> hazard unit signal bundle (stage state in, stage controls out).
// Latency: pure wiring, no storage.
// Backpressure: none here; stalls are carried as ordinary control signals.
interface hazard_unit_sb_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  // Pipeline state presented to the hazard unit
  logic              ICacheMiss;
  logic              DCacheMiss;
  logic              BranchE;
  logic              JalrE;
  logic              JalD;
  logic [ADDR_W-1:0] Rs1D;
  logic [ADDR_W-1:0] Rs2D;
  logic [ADDR_W-1:0] Rs1E;
  logic [ADDR_W-1:0] Rs2E;
  logic [ADDR_W-1:0] RdE;
  logic [ADDR_W-1:0] RdM;
  logic [ADDR_W-1:0] RdW;
  logic [1:0]        RegReadD;
  logic [1:0]        RegReadE;
  logic              RegWriteE;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemToRegE;
  logic              LongOpE;

  // Stage controls and long-unit status returned to the pipeline
  logic              StallF, FlushF;
  logic              StallD, FlushD;
  logic              StallE, FlushE;
  logic              StallM, FlushM;
  logic              StallW, FlushW;
  logic [1:0]        Forward1E;
  logic [1:0]        Forward2E;
  logic              LongBusy;
  logic [ADDR_W-1:0] LongRd;
  logic              LongWb;
  logic [CNT_W-1:0]  StallCnt;

  // Pipeline side
  modport master (
    output ICacheMiss, DCacheMiss, BranchE, JalrE, JalD,
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadD, RegReadE,
    output RegWriteE, RegWriteM, RegWriteW, MemToRegE, LongOpE,
    input  StallF, FlushF, StallD, FlushD, StallE, FlushE,
    input  StallM, FlushM, StallW, FlushW,
    input  Forward1E, Forward2E, LongBusy, LongRd, LongWb, StallCnt
  );

  // Hazard unit side
  modport slave (
    input  ICacheMiss, DCacheMiss, BranchE, JalrE, JalD,
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadD, RegReadE,
    input  RegWriteE, RegWriteM, RegWriteW, MemToRegE, LongOpE,
    output StallF, FlushF, StallD, FlushD, StallE, FlushE,
    output StallM, FlushM, StallW, FlushW,
    output Forward1E, Forward2E, LongBusy, LongRd, LongWb, StallCnt
  );
endinterface

// File: rtl/hazard_unit_sb.sv
// Purpose: 5-stage pipeline stall/flush/forward control with a mul/div scoreboard and stall counter.
// Latency: controls combinational; long op completes LONG_LAT-1 cycles after acceptance (plus deferrals).
// Backpressure: cache misses and long-unit conflicts stall the pipeline; W owns the write port over the long result.
module hazard_unit_sb #(
  parameter int ADDR_W   = 5,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             CpuRstN,
  hazard_unit_sb_if.slave  hz
);

  localparam logic [7:0] LAT_M1 = 8'(LONG_LAT - 1);

  logic              long_busy;
  logic [ADDR_W-1:0] long_rd;
  logic [7:0]        long_cnt;
  logic              long_wb;
  logic              long_acc;
  logic [CNT_W-1:0]  stall_cnt;
  logic [4:0]        st;   // {F,D,E,M,W}
  logic [4:0]        fl;   // {F,D,E,M,W}
  logic              br_e;
  logic              d_haz;
  logic [1:0]        fwd1;
  logic [1:0]        fwd2;

  // A destination feeds a D-stage source that is actually read
  function automatic logic src_match(input logic [ADDR_W-1:0] rd,
                                     input logic [ADDR_W-1:0] rs1,
                                     input logic [ADDR_W-1:0] rs2,
                                     input logic [1:0]        used);
    return ((rd == rs1) && used[1]) || ((rd == rs2) && used[0]);
  endfunction

  // Select the newest producer of an E-stage source; x0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs, input logic used,
                                         input logic wm, input logic [ADDR_W-1:0] rdm,
                                         input logic ww, input logic [ADDR_W-1:0] rdw);
    if (wm && (rdm != '0) && (rdm == rs) && used)      return 2'b10;
    else if (ww && (rdw != '0) && (rdw == rs) && used) return 2'b01;
    else                                               return 2'b00;
  endfunction

  assign br_e    = hz.BranchE | hz.JalrE;
  // The long result only takes the write port when W is idle and memory is not frozen
  assign long_wb = long_busy & (long_cnt == 8'd0) & ~hz.RegWriteW & ~hz.DCacheMiss;

  // Consumer in D must wait for a load in E or any pending long-unit result
  assign d_haz =
      (hz.MemToRegE & hz.RegWriteE & (hz.RdE != '0) &
       src_match(hz.RdE, hz.Rs1D, hz.Rs2D, hz.RegReadD)) |
      (hz.LongOpE & (hz.RdE != '0) &
       src_match(hz.RdE, hz.Rs1D, hz.Rs2D, hz.RegReadD)) |
      (long_busy & (long_rd != '0) &
       src_match(long_rd, hz.Rs1D, hz.Rs2D, hz.RegReadD));

  // Prioritised stall/flush decision, first matching cause wins
  always_comb begin
    st = 5'b00000;
    fl = 5'b00000;
    if (hz.DCacheMiss) begin
      st = 5'b11111;
    end else if (hz.ICacheMiss && br_e) begin
      st = 5'b11100;
      fl = 5'b00010;
    end else if (hz.LongOpE && long_busy && !long_wb) begin
      st = 5'b11100;
      fl = 5'b00010;
    end else if (d_haz) begin
      st = 5'b11000;
      fl = 5'b00100;
    end else if (br_e) begin
      fl = 5'b01100;
    end else if (hz.ICacheMiss) begin
      st = 5'b10000;
      fl = 5'b01000;
    end else if (hz.JalD) begin
      fl = 5'b01000;
    end
  end

  assign fwd1 = fwd_sel(hz.Rs1E, hz.RegReadE[1], hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign fwd2 = fwd_sel(hz.Rs2E, hz.RegReadE[0], hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  // A long op leaves E into the unit when E advances; a completing op frees the slot this edge
  assign long_acc = hz.LongOpE & ~st[2] & ~fl[2] & (~long_busy | long_wb);

  // Long-unit scoreboard: accept, count down (frozen on D-miss), retire on writeback
  always_ff @(posedge clk or negedge CpuRstN) begin
    if (!CpuRstN) begin
      long_busy <= 1'b0;
      long_rd   <= '0;
      long_cnt  <= 8'd0;
    end else if (long_acc) begin
      long_busy <= 1'b1;
      long_rd   <= hz.RdE;
      long_cnt  <= LAT_M1;
    end else if (long_wb) begin
      long_busy <= 1'b0;
    end else if (long_busy && (long_cnt != 8'd0) && !hz.DCacheMiss) begin
      long_cnt  <= long_cnt - 8'd1;
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or negedge CpuRstN) begin
    if (!CpuRstN) begin
      stall_cnt <= '0;
    end else if (st[4] && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW} = st;
  assign {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW} = fl;
  assign hz.Forward1E = fwd1;
  assign hz.Forward2E = fwd2;
  assign hz.LongBusy  = long_busy;
  assign hz.LongRd    = long_rd;
  assign hz.LongWb    = long_wb;
  assign hz.StallCnt  = stall_cnt;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Purpose: directed checks of hazard_unit_sb controls, forwarding, long-unit scoreboard and counter.
// Latency: inputs driven at negedge, sampled 1 ns later; state advances at posedge.
// Backpressure: not applicable.
module tb_hazard_unit_sb;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic clk;
  logic CpuRstN;
  int   n_chk;
  int   n_err;

  hazard_unit_sb_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) hz ();

  hazard_unit_sb #(.ADDR_W(ADDR_W), .LONG_LAT(4), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .CpuRstN (CpuRstN),
    .hz      (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ic, dc, br, jalr, jald;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rrd, rre;
    logic       rwe, rwm, rww, m2r, lop;
    logic [4:0] es, ef;          // expected stall/flush {F,D,E,M,W}
    logic [1:0] ef1, ef2;        // expected forward selects
  } vec_t;

  vec_t q[$];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] stall_v();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW};
  endfunction

  function automatic logic [4:0] flush_v();
    return {hz.FlushF, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};
  endfunction

  task automatic clear_in();
    hz.ICacheMiss = 0; hz.DCacheMiss = 0; hz.BranchE = 0; hz.JalrE = 0; hz.JalD = 0;
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    hz.RdE = 0; hz.RdM = 0; hz.RdW = 0; hz.RegReadD = 0; hz.RegReadE = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MemToRegE = 0; hz.LongOpE = 0;
  endtask

  task automatic apply(input vec_t x);
    hz.ICacheMiss = x.ic; hz.DCacheMiss = x.dc; hz.BranchE = x.br; hz.JalrE = x.jalr;
    hz.JalD = x.jald; hz.Rs1D = x.rs1d; hz.Rs2D = x.rs2d; hz.Rs1E = x.rs1e; hz.Rs2E = x.rs2e;
    hz.RdE = x.rde; hz.RdM = x.rdm; hz.RdW = x.rdw; hz.RegReadD = x.rrd; hz.RegReadE = x.rre;
    hz.RegWriteE = x.rwe; hz.RegWriteM = x.rwm; hz.RegWriteW = x.rww;
    hz.MemToRegE = x.m2r; hz.LongOpE = x.lop;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    CpuRstN = 1'b0;
    @(negedge clk);
    CpuRstN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    CpuRstN = 1'b0;
    clear_in();

    // Vector table: combinational behaviour with the long unit idle
    v = '{default: '0}; q.push_back(v);
    v = '{default: '0}; v.m2r = 1; v.rwe = 1; v.rde = 3; v.rs2d = 3; v.rrd = 2'b01;
    v.es = 5'b11000; v.ef = 5'b00100; q.push_back(v);
    v = '{default: '0}; v.m2r = 1; v.rwe = 1; v.rde = 0; v.rs2d = 0; v.rrd = 2'b01; q.push_back(v);
    v = '{default: '0}; v.m2r = 1; v.rwe = 1; v.rde = 3; v.rs1d = 3; v.rs2d = 4; v.rrd = 2'b01; q.push_back(v);
    v = '{default: '0}; v.m2r = 1; v.rwe = 0; v.rde = 3; v.rs2d = 3; v.rrd = 2'b01; q.push_back(v);
    v = '{default: '0}; v.lop = 1; v.rde = 6; v.rs1d = 6; v.rrd = 2'b10;
    v.es = 5'b11000; v.ef = 5'b00100; q.push_back(v);
    v = '{default: '0}; v.rdm = 9; v.rdw = 9; v.rs1e = 9; v.rwm = 1; v.rww = 1; v.rre = 2'b10;
    v.ef1 = 2'b10; q.push_back(v);
    v = '{default: '0}; v.rdm = 9; v.rdw = 9; v.rs1e = 9; v.rwm = 0; v.rww = 1; v.rre = 2'b10;
    v.ef1 = 2'b01; q.push_back(v);
    v = '{default: '0}; v.rdm = 12; v.rs2e = 12; v.rwm = 1; v.rre = 2'b01; v.ef2 = 2'b10; q.push_back(v);
    v = '{default: '0}; v.rdm = 0; v.rs1e = 0; v.rwm = 1; v.rre = 2'b10; q.push_back(v);
    v = '{default: '0}; v.rdm = 12; v.rs2e = 12; v.rwm = 1; v.rre = 2'b10; q.push_back(v);
    v = '{default: '0}; v.ic = 1; v.br = 1; v.es = 5'b11100; v.ef = 5'b00010; q.push_back(v);
    v = '{default: '0}; v.ic = 1; v.br = 1; v.dc = 1; v.es = 5'b11111; q.push_back(v);
    v = '{default: '0}; v.br = 1; v.ef = 5'b01100; q.push_back(v);
    v = '{default: '0}; v.jalr = 1; v.ef = 5'b01100; q.push_back(v);
    v = '{default: '0}; v.ic = 1; v.es = 5'b10000; v.ef = 5'b01000; q.push_back(v);
    v = '{default: '0}; v.jald = 1; v.ef = 5'b01000; q.push_back(v);
    v = '{default: '0}; v.m2r = 1; v.rwe = 1; v.rde = 3; v.rs2d = 3; v.rrd = 2'b01; v.br = 1;
    v.es = 5'b11000; v.ef = 5'b00100; q.push_back(v);
    v = '{default: '0}; v.ic = 1; v.jald = 1; v.es = 5'b10000; v.ef = 5'b01000; q.push_back(v);
    v = '{default: '0}; v.dc = 1; v.rdw = 4; v.rs2e = 4; v.rww = 1; v.rre = 2'b01;
    v.es = 5'b11111; v.ef2 = 2'b01; q.push_back(v);

    // Reset state
    #2;
    chk("rst_stall", 32'(stall_v()), 0);
    chk("rst_flush", 32'(flush_v()), 0);
    chk("rst_busy", 32'(hz.LongBusy), 0);
    chk("rst_rd", 32'(hz.LongRd), 0);
    chk("rst_wb", 32'(hz.LongWb), 0);
    chk("rst_cnt", 32'(hz.StallCnt), 0);
    @(negedge clk);
    CpuRstN = 1'b1;

    // Table: drive between edges only, so no state is disturbed
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      apply(q[i]);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall_v()), 32'(q[i].es));
      chk($sformatf("vec%0d_flush", i), 32'(flush_v()), 32'(q[i].ef));
      chk($sformatf("vec%0d_fwd1", i), 32'(hz.Forward1E), 32'(q[i].ef1));
      chk($sformatf("vec%0d_fwd2", i), 32'(hz.Forward2E), 32'(q[i].ef2));
      #1;
      clear_in();
    end
    #1;
    chk("tbl_cnt_idle", 32'(hz.StallCnt), 0);

    // Long latency with a dependent consumer entering D
    do_reset();
    @(negedge clk);
    hz.LongOpE = 1; hz.RdE = 7;
    #1;
    chk("lat_issue_stall", 32'(stall_v()), 0);
    @(negedge clk);
    clear_in();
    hz.Rs1D = 7; hz.RegReadD = 2'b10;
    for (int k = 0; k <= 4; k++) begin
      #1;
      chk($sformatf("lat_k%0d_stallD", k), 32'(hz.StallD), (k <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat_k%0d_wb", k), 32'(hz.LongWb), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat_k%0d_busy", k), 32'(hz.LongBusy), (k <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat_k%0d_cnt", k), 32'(hz.StallCnt), 32'(k));
      if (k == 0) chk("lat_rd", 32'(hz.LongRd), 7);
      @(negedge clk);
    end
    clear_in();

    // Writeback conflict, back-to-back acceptance, structural hazard, D-miss freeze
    do_reset();
    @(negedge clk);
    hz.LongOpE = 1; hz.RdE = 8;
    @(negedge clk);
    clear_in();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wbc_k%0d_wb", k), 32'(hz.LongWb), 0);
      @(negedge clk);
    end
    hz.RegWriteW = 1; hz.RdW = 2;
    #1;
    chk("wbc_defer_wb", 32'(hz.LongWb), 0);
    chk("wbc_defer_busy", 32'(hz.LongBusy), 1);
    @(negedge clk);
    hz.RegWriteW = 0; hz.RdW = 0; hz.LongOpE = 1; hz.RdE = 10;
    #1;
    chk("wbc_late_wb", 32'(hz.LongWb), 1);
    chk("b2b_no_stall", 32'(stall_v()), 0);
    @(negedge clk);
    #1;
    chk("b2b_busy", 32'(hz.LongBusy), 1);
    chk("b2b_rd", 32'(hz.LongRd), 10);
    chk("struct_stall", 32'(stall_v()), 32'b11100);
    chk("struct_flush", 32'(flush_v()), 32'b00010);
    @(negedge clk);
    clear_in();
    hz.DCacheMiss = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("frz_k%0d_stall", k), 32'(stall_v()), 32'b11111);
      chk($sformatf("frz_k%0d_flush", k), 32'(flush_v()), 0);
      @(negedge clk);
    end
    hz.DCacheMiss = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("frz_after%0d_wb", k), 32'(hz.LongWb), (k == 2) ? 32'd1 : 32'd0);
      chk($sformatf("frz_after%0d_busy", k), 32'(hz.LongBusy), (k <= 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Miss/branch interaction and stall counting
    do_reset();
    @(negedge clk);
    hz.ICacheMiss = 1; hz.BranchE = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("mb_k%0d_stall", k), 32'(stall_v()), 32'b11100);
      chk($sformatf("mb_k%0d_flush", k), 32'(flush_v()), 32'b00010);
      @(negedge clk);
    end
    hz.DCacheMiss = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("mbd_k%0d_stall", k), 32'(stall_v()), 32'b11111);
      @(negedge clk);
    end
    clear_in();
    hz.BranchE = 1;
    #1;
    chk("mb_cnt5", 32'(hz.StallCnt), 5);
    @(negedge clk);
    @(negedge clk);
    clear_in();
    #1;
    chk("mb_cnt_hold", 32'(hz.StallCnt), 5);

    // Reset asserted while a long op is in flight
    @(negedge clk);
    hz.ICacheMiss = 1;
    @(negedge clk);
    clear_in();
    hz.LongOpE = 1; hz.RdE = 5;
    @(negedge clk);
    clear_in();
    #1;
    chk("rmid_busy_pre", 32'(hz.LongBusy), 1);
    @(negedge clk);
    #2;
    CpuRstN = 1'b0;
    #1;
    chk("rmid_busy", 32'(hz.LongBusy), 0);
    chk("rmid_rd", 32'(hz.LongRd), 0);
    chk("rmid_cnt", 32'(hz.StallCnt), 0);
    @(negedge clk);
    CpuRstN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rmid_k%0d_wb", k), 32'(hz.LongWb), 0);
      @(negedge clk);
    end

    // Counter saturation
    do_reset();
    @(negedge clk);
    hz.ICacheMiss = 1;
    for (int k = 0; k < 15; k++) @(negedge clk);
    #1;
    chk("sat_at_max", 32'(hz.StallCnt), 15);
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    chk("sat_hold", 32'(hz.StallCnt), 15);
    clear_in();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
